// File: rtl/hough_frame_ctrl_if.sv
// Host, source-stream and pipeline-side signals of the Hough frame sequencer.
interface hough_frame_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             Start;
    logic             Abort;
    logic [CNT_W-1:0] NumFrames;
    logic [7:0]       PixelIn;
    logic             FrameIn;
    logic             LineIn;
    logic             FrameRet;
    logic [7:0]       PixelGated;
    logic             FrameGated;
    logic             LineGated;
    logic             Busy;
    logic             Done;
    logic             Error;
    logic [CNT_W-1:0] FramesDone;

    modport master (
        output Start, Abort, NumFrames, PixelIn, FrameIn, LineIn, FrameRet,
        input  PixelGated, FrameGated, LineGated, Busy, Done, Error, FramesDone
    );

    modport slave (
        input  Start, Abort, NumFrames, PixelIn, FrameIn, LineIn, FrameRet,
        output PixelGated, FrameGated, LineGated, Busy, Done, Error, FramesDone
    );
endinterface

// File: rtl/hough_frame_ctrl.sv
// Frame sequencer: gates NumFrames whole source frames into the Hough pipeline, drains, checks returns.
// Optional watchdog on ARM/RUN stalls enabled by defining HOUGH_FRAME_CTRL_WDOG_EN.
module hough_frame_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DRAIN_CYCLES = 1024
`ifdef HOUGH_FRAME_CTRL_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES  = 1048576
`endif
) (
    input logic               Clk,
    input logic               nReset,
    hough_frame_ctrl_if.slave bus
);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNxt;
    logic [CNT_W-1:0]   numLat;
    logic [CNT_W-1:0]   numNxt;
    logic [CNT_W-1:0]   inCnt;
    logic [CNT_W-1:0]   inNxt;
    logic [DRAIN_W-1:0] drainCnt;
    logic [DRAIN_W-1:0] drainNxt;
    logic [CNT_W-1:0]   framesNxt;
    logic               errNxt;
    logic               doneNxt;
    logic               passNow;

`ifdef HOUGH_FRAME_CTRL_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 2);
    logic [WDOG_W-1:0]  wdogCnt;
    logic [WDOG_W-1:0]  wdogNxt;
`endif

    // State and counter registers
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            numLat   <= '0;
            inCnt    <= '0;
            drainCnt <= '0;
        end else begin
            state    <= stateNxt;
            numLat   <= numNxt;
            inCnt    <= inNxt;
            drainCnt <= drainNxt;
        end
    end

`ifdef HOUGH_FRAME_CTRL_WDOG_EN
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wdogCnt <= '0;
        end else begin
            wdogCnt <= wdogNxt;
        end
    end
`endif

    // Next-state, gate decision and status updates
    always_comb begin
        stateNxt  = state;
        numNxt    = numLat;
        inNxt     = inCnt;
        drainNxt  = drainCnt;
        errNxt    = bus.Error;
        doneNxt   = 1'b0;
        passNow   = 1'b0;
        framesNxt = bus.FramesDone;
`ifdef HOUGH_FRAME_CTRL_WDOG_EN
        wdogNxt   = '0;
`endif

        // Returned frames count only while a run is in flight, saturating
        if (state != IDLE && bus.FrameRet && bus.FramesDone != '1) begin
            framesNxt = bus.FramesDone + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    errNxt = 1'b0;
                    if (bus.NumFrames != '0) begin
                        numNxt    = bus.NumFrames;
                        inNxt     = '0;
                        framesNxt = '0;
                        stateNxt  = ARM;
                    end else begin
                        doneNxt = 1'b1;
                    end
                end
            end
            ARM: begin
                if (bus.FrameIn) begin
                    passNow  = 1'b1;
                    inNxt    = CNT_W'(1);
                    stateNxt = RUN;
                end
            end
            RUN: begin
                passNow = 1'b1;
                if (bus.FrameIn) begin
                    if (inCnt < numLat) begin
                        inNxt = inCnt + 1'b1;
                    end else begin
                        // This FrameIn would start one frame too many: block it
                        passNow  = 1'b0;
                        drainNxt = DRAIN_W'(DRAIN_CYCLES);
                        stateNxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drainNxt = drainCnt - 1'b1;
                if (drainCnt <= DRAIN_W'(1)) begin
                    drainNxt = '0;
                    doneNxt  = 1'b1;
                    errNxt   = bus.Error | (framesNxt != numLat);
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase

`ifdef HOUGH_FRAME_CTRL_WDOG_EN
        // Watchdog restarts on every FrameIn and on entry to ARM/RUN
        if ((state == ARM || state == RUN) && !bus.FrameIn) begin
            if (wdogCnt >= WDOG_W'(WDOG_CYCLES - 1)) begin
                errNxt   = 1'b1;
                doneNxt  = 1'b1;
                passNow  = 1'b0;
                stateNxt = IDLE;
            end else begin
                wdogNxt = wdogCnt + 1'b1;
            end
        end
`endif

        if (bus.Abort) begin
            stateNxt  = IDLE;
            passNow   = 1'b0;
            doneNxt   = 1'b0;
            errNxt    = bus.Error;
            framesNxt = bus.FramesDone;
`ifdef HOUGH_FRAME_CTRL_WDOG_EN
            wdogNxt   = '0;
`endif
        end
    end

    // Registered gated stream and status outputs
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bus.PixelGated <= '0;
            bus.FrameGated <= 1'b0;
            bus.LineGated  <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.Done       <= 1'b0;
            bus.Error      <= 1'b0;
            bus.FramesDone <= '0;
        end else begin
            bus.PixelGated <= passNow ? bus.PixelIn : 8'd0;
            bus.FrameGated <= passNow & bus.FrameIn;
            bus.LineGated  <= passNow & bus.LineIn;
            bus.Busy       <= (stateNxt != IDLE);
            bus.Done       <= doneNxt;
            bus.Error      <= errNxt;
            bus.FramesDone <= framesNxt;
        end
    end

endmodule

// File: tb/tb_hough_frame_ctrl.sv
// Directed bench for hough_frame_ctrl: 640x3 source frames, echoing pipeline model, run/abort scenarios.
module tb_hough_frame_ctrl;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned DRAIN     = 64;
    localparam int unsigned LINE_LEN  = 640;
    localparam int unsigned FRAME_LEN = LINE_LEN * 3;
    localparam int unsigned RET_DLY   = 5;

    logic Clk;
    logic nReset;
    hough_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hough_frame_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        retEn = 1'b0;
    logic [RET_DLY-1:0] retPipe = '0;
    int unsigned srcPos = FRAME_LEN - 1;

    // Monitor results
    int mGated, mPix, mLeak, mFirstLat, mDoneDelta;
    logic mErr;
    logic [CNT_W-1:0] mFd;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Free-running 640x3 source, no blanking; pixel values never zero
    initial begin
        bus.PixelIn = '0;
        bus.FrameIn = 1'b0;
        bus.LineIn  = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            srcPos      = (srcPos == FRAME_LEN - 1) ? 0 : srcPos + 1;
            bus.FrameIn = (srcPos == 0);
            bus.LineIn  = (srcPos % LINE_LEN == 0);
            bus.PixelIn = 8'((srcPos % 251) + 1);
        end
    end

    // Pipeline model: returns each gated frame start RET_DLY cycles later
    initial begin
        bus.FrameRet = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            retPipe      = {retPipe[RET_DLY-2:0], bus.FrameGated};
            bus.FrameRet = retEn & retPipe[RET_DLY-1];
        end
    end

    task automatic hostPulse(input logic [CNT_W-1:0] n, input logic doStart, input logic doAbort);
        @(posedge Clk);
        #1;
        bus.Start     = doStart;
        bus.Abort     = doAbort;
        bus.NumFrames = n;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
    endtask

    task automatic idleWindow(input int len, output int leaks, output int busyCnt, output int doneCnt);
        leaks = 0; busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge Clk);
            if (bus.PixelGated != 0 || bus.FrameGated || bus.LineGated) leaks++;
            if (bus.Busy) busyCnt++;
            if (bus.Done) doneCnt++;
        end
    endtask

    // Follows one run from just after Start until Done or the cycle budget expires
    task automatic runMonitor(input int n);
        int fin = 0;
        int closeCyc = -1;
        int firstIn = -1;
        int firstGate = -1;
        int maxCyc = (n + 2) * FRAME_LEN + DRAIN + 50;
        mGated = 0; mPix = 0; mLeak = 0; mDoneDelta = -1; mErr = 1'bx; mFd = 'x;
        for (int cyc = 1; cyc <= maxCyc; cyc++) begin
            @(negedge Clk);
            if (bus.FrameGated) begin
                mGated++;
                if (firstGate < 0) firstGate = cyc;
            end
            if (bus.PixelGated != 0) mPix++;
            if (closeCyc >= 0 && (bus.PixelGated != 0 || bus.FrameGated || bus.LineGated)) mLeak++;
            if (bus.FrameIn) begin
                fin++;
                if (fin == 1) firstIn = cyc;
                if (fin == n + 1) closeCyc = cyc;
            end
            if (bus.Done) begin
                mDoneDelta = (closeCyc >= 0) ? cyc - closeCyc : -1;
                mErr = bus.Error;
                mFd  = bus.FramesDone;
                break;
            end
        end
        mFirstLat = (firstGate >= 0 && firstIn >= 0) ? firstGate - firstIn : -1;
    endtask

    task automatic checkRun(input string tag, input int n, input logic expErr, input int expFd);
        checkEq({tag, ".firstLat"}, mFirstLat, 1);
        checkEq({tag, ".gatedFrames"}, mGated, n);
        checkEq({tag, ".gatedPixels"}, mPix, n * FRAME_LEN);
        checkEq({tag, ".leakAfterClose"}, mLeak, 0);
        // Drain timer loads on the edge that samples the closing FrameIn
        checkEq({tag, ".doneDelay"}, mDoneDelta, DRAIN + 1);
        checkEq({tag, ".error"}, mErr, expErr);
        checkEq({tag, ".framesDone"}, mFd, expFd);
        @(negedge Clk);
        checkEq({tag, ".donePulseWidth"}, bus.Done, 0);
        checkEq({tag, ".busyAfterDone"}, bus.Busy, 0);
    endtask

    initial begin
        int leaks, busyCnt, doneCnt;
        logic seen;
        bus.Start     = 1'b0;
        bus.Abort     = 1'b0;
        bus.NumFrames = '0;
        nReset        = 1'b0;

        // Reset values
        repeat (3) @(negedge Clk);
        checkEq("rst.pixel", bus.PixelGated, 0);
        checkEq("rst.frame", bus.FrameGated, 0);
        checkEq("rst.busy", bus.Busy, 0);
        checkEq("rst.done", bus.Done, 0);
        checkEq("rst.error", bus.Error, 0);
        checkEq("rst.framesDone", bus.FramesDone, 0);
        @(posedge Clk);
        #1;
        nReset = 1'b1;

        // Two source frames with no Start
        idleWindow(2 * FRAME_LEN, leaks, busyCnt, doneCnt);
        checkEq("idle.leaks", leaks, 0);
        checkEq("idle.busy", busyCnt, 0);
        checkEq("idle.done", doneCnt, 0);

        // NumFrames=2 started mid-frame, pipeline returns every frame
        retEn = 1'b1;
        repeat (FRAME_LEN / 3) @(negedge Clk);
        hostPulse(8'd2, 1'b1, 1'b0);
        runMonitor(2);
        checkRun("run2", 2, 1'b0, 2);

        // Same run with no returns
        retEn = 1'b0;
        repeat (FRAME_LEN / 3) @(negedge Clk);
        hostPulse(8'd2, 1'b1, 1'b0);
        runMonitor(2);
        checkRun("noret2", 2, 1'b1, 0);

        // NumFrames=0: immediate Done, clears Error, no traffic
        hostPulse(8'd0, 1'b1, 1'b0);
        @(negedge Clk);
        checkEq("zero.done", bus.Done, 1);
        checkEq("zero.busy", bus.Busy, 0);
        checkEq("zero.errorCleared", bus.Error, 0);
        idleWindow(FRAME_LEN / 2, leaks, busyCnt, doneCnt);
        checkEq("zero.leaks", leaks, 0);
        checkEq("zero.busyLater", busyCnt, 0);
        checkEq("zero.doneOnce", doneCnt, 0);

        // One frame without returns to leave Error set
        hostPulse(8'd1, 1'b1, 1'b0);
        runMonitor(1);
        checkRun("noret1", 1, 1'b1, 0);

        // Start and Abort together: Abort wins, Error untouched
        hostPulse(8'd4, 1'b1, 1'b1);
        @(negedge Clk);
        checkEq("startAbort.busy", bus.Busy, 0);
        checkEq("startAbort.errorKept", bus.Error, 1);
        idleWindow(FRAME_LEN + 10, leaks, busyCnt, doneCnt);
        checkEq("startAbort.leaks", leaks, 0);
        checkEq("startAbort.done", doneCnt, 0);

        // Abort halfway through frame 1 of 3
        retEn = 1'b1;
        hostPulse(8'd3, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            @(negedge Clk);
            if (bus.FrameGated) begin
                seen = 1'b1;
                break;
            end
        end
        checkEq("abort.firstFrameGated", seen, 1);
        repeat (FRAME_LEN / 2) @(negedge Clk);
        checkEq("abort.busyBefore", bus.Busy, 1);
        checkEq("abort.pixelBefore", bus.PixelGated != 0, 1);
        hostPulse(8'd3, 1'b0, 1'b1);
        @(negedge Clk);
        checkEq("abort.pixel", bus.PixelGated, 0);
        checkEq("abort.line", bus.LineGated, 0);
        checkEq("abort.busy", bus.Busy, 0);
        checkEq("abort.done", bus.Done, 0);
        checkEq("abort.errorKept", bus.Error, 0);
        checkEq("abort.framesKept", bus.FramesDone, 1);
        idleWindow(2 * FRAME_LEN, leaks, busyCnt, doneCnt);
        checkEq("abort.leaksAfter", leaks, 0);
        checkEq("abort.busyAfter", busyCnt, 0);
        checkEq("abort.doneAfter", doneCnt, 0);
        checkEq("abort.framesHeld", bus.FramesDone, 1);

        // Normal single-frame run after the abort
        hostPulse(8'd1, 1'b1, 1'b0);
        @(negedge Clk);
        checkEq("run1.busy", bus.Busy, 1);
        checkEq("run1.framesCleared", bus.FramesDone, 0);
        runMonitor(1);
        checkRun("run1", 1, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
